bcd_counter_multi: RTL and testbench

- Parametrised multi-digit BCD up/down counter; successor to the single-digit cascadable BCD counter.
- Adds a runtime direction control, a programmable terminal value, synchronous parallel load with BCD validation, and wrap or saturate behaviour.
- Sits in display, timer and event-count datapaths where several digits used to be cascaded by hand.

---
 rtl/bcd_pkg.sv | 12 +
 rtl/bcd_digit_step.sv | 40 ++++
 rtl/bcd_counter_multi.sv | 103 ++++++++++
 tb/tb_bcd_counter_multi.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD types, constants and digit validation for the multi-digit counter.
package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX = 4'd9;

   function automatic logic is_bcd(input bcd_digit_t digit);
      return (digit <= BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// Combinational single-digit BCD cell: steps one digit up or down when cin is set
// and reports the carry/borrow into the next digit.
module bcd_digit_step
   import bcd_pkg::*;
(
   input  logic [3:0] d,
   input  logic       up,
   input  logic       cin,
   output logic [3:0] d_next,
   output logic       cout
);

   // Next digit value and carry/borrow out for one enabled step.
   always_comb begin
      d_next = d;
      cout   = 1'b0;
      if (!cin) begin
         d_next = d;
         cout   = 1'b0;
      end else if (up) begin
         // Out-of-range digits also roll to 0 so a bad limit cannot stall the chain.
         if (d >= BCD_MAX) begin
            d_next = 4'd0;
            cout   = 1'b1;
         end else begin
            d_next = d + 4'd1;
            cout   = 1'b0;
         end
      end else begin
         if (d == 4'd0) begin
            d_next = BCD_MAX;
            cout   = 1'b1;
         end else begin
            d_next = d - 4'd1;
            cout   = 1'b0;
         end
      end
   end

endmodule

// File: rtl/bcd_counter_multi.sv
// Multi-digit BCD up/down counter with programmable terminal value, validated
// parallel load and wrap/saturate boundary behaviour.
module bcd_counter_multi
   import bcd_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter bit SATURATE   = 1'b0
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    clr,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] load_val,
   input  logic                    en,
   input  logic                    up,
   input  logic [4*NUM_DIGITS-1:0] limit,
   output logic [4*NUM_DIGITS-1:0] q,
   output logic                    tc,
   output logic                    load_err,
   output logic                    lim_err
);

   localparam int W = 4 * NUM_DIGITS;

   logic [W-1:0]          cnt_q, cnt_d;
   logic                  tc_q, tc_d;
   logic                  lerr_q, lerr_d;
   logic [W-1:0]          step_s;
   logic [NUM_DIGITS:0]   carry_s;
   logic [NUM_DIGITS-1:0] ld_ok_s;
   logic [NUM_DIGITS-1:0] lim_ok_s;
   logic                  chain_out_s;

   assign carry_s[0] = 1'b1;

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      bcd_digit_step u_step (
         .d      (cnt_q[4*g +: 4]),
         .up     (up),
         .cin    (carry_s[g]),
         .d_next (step_s[4*g +: 4]),
         .cout   (carry_s[g+1])
      );
      assign ld_ok_s[g]  = is_bcd(load_val[4*g +: 4]);
      assign lim_ok_s[g] = is_bcd(limit[4*g +: 4]);
   end

   // When counting down, a borrow out of the top digit means every digit was 0.
   assign chain_out_s = carry_s[NUM_DIGITS];

   // Priority select of the next count: clr, then load, then enabled step.
   always_comb begin
      cnt_d  = cnt_q;
      tc_d   = 1'b0;
      lerr_d = 1'b0;
      if (clr) begin
         cnt_d = {W{1'b0}};
      end else if (load) begin
         if (&ld_ok_s) begin
            cnt_d = load_val;
         end else begin
            lerr_d = 1'b1;
         end
      end else if (en) begin
         if (up) begin
            if (cnt_q >= limit) begin
               tc_d  = 1'b1;
               cnt_d = SATURATE ? cnt_q : {W{1'b0}};
            end else begin
               cnt_d = step_s;
            end
         end else begin
            if (chain_out_s) begin
               tc_d  = 1'b1;
               cnt_d = SATURATE ? {W{1'b0}} : limit;
            end else begin
               cnt_d = step_s;
            end
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State and pulse registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt_q  <= {W{1'b0}};
         tc_q   <= 1'b0;
         lerr_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tc_q   <= tc_d;
         lerr_q <= lerr_d;
      end
   end

   assign q        = cnt_q;
   assign tc       = tc_q;
   assign load_err = lerr_q;
   assign lim_err  = ~(&lim_ok_s);

endmodule

// File: tb/tb_bcd_counter_multi.sv
// Directed bench: two 2-digit counters (wrap and saturate) share stimulus,
// a 4-digit wrap counter exercises multi-digit ripple.
module tb_bcd_counter_multi;

   logic        clk = 1'b0;
   logic        rstn, clr, load, en, up;
   logic [7:0]  load_val, limit;
   logic [7:0]  qa, qb;
   logic        tca, tcb, lea, leb, lima, limb;
   logic        c_clr, c_load, c_en, c_up;
   logic [15:0] c_load_val, c_limit, qc;
   logic        tcc, lec, limc;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   bcd_counter_multi #(.NUM_DIGITS(2), .SATURATE(1'b0)) dut_a (
      .clk(clk), .rstn(rstn), .clr(clr), .load(load), .load_val(load_val),
      .en(en), .up(up), .limit(limit), .q(qa), .tc(tca), .load_err(lea), .lim_err(lima));

   bcd_counter_multi #(.NUM_DIGITS(2), .SATURATE(1'b1)) dut_b (
      .clk(clk), .rstn(rstn), .clr(clr), .load(load), .load_val(load_val),
      .en(en), .up(up), .limit(limit), .q(qb), .tc(tcb), .load_err(leb), .lim_err(limb));

   bcd_counter_multi #(.NUM_DIGITS(4), .SATURATE(1'b0)) dut_c (
      .clk(clk), .rstn(rstn), .clr(c_clr), .load(c_load), .load_val(c_load_val),
      .en(c_en), .up(c_up), .limit(c_limit), .q(qc), .tc(tcc), .load_err(lec), .lim_err(limc));

   function automatic logic [7:0] bcd2(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a(input string name, input logic [7:0] eq, input logic etc, input logic ele);
      checks++;
      if (qa !== eq || tca !== etc || lea !== ele) begin
         errors++;
         $display("FAIL %s (wrap): got q=%h tc=%b load_err=%b, want q=%h tc=%b load_err=%b",
                  name, qa, tca, lea, eq, etc, ele);
      end
   endtask

   task automatic chk_b(input string name, input logic [7:0] eq, input logic etc, input logic ele);
      checks++;
      if (qb !== eq || tcb !== etc || leb !== ele) begin
         errors++;
         $display("FAIL %s (sat): got q=%h tc=%b load_err=%b, want q=%h tc=%b load_err=%b",
                  name, qb, tcb, leb, eq, etc, ele);
      end
   endtask

   task automatic load_ab(input logic [7:0] v);
      load = 1'b1; en = 1'b0; load_val = v;
      step();
      load = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0; en = 1'b1; up = 1'b1; load = 1'b1; load_val = 8'h12; clr = 1'b0;
      limit = 8'h59;
      c_en = 1'b1; c_up = 1'b1; c_load = 1'b1; c_load_val = 16'h1234; c_clr = 1'b0;
      c_limit = 16'h9999;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_a("reset", 8'h00, 1'b0, 1'b0);
         chk_b("reset", 8'h00, 1'b0, 1'b0);
         checks++;
         if (qc !== 16'h0000 || tcc !== 1'b0 || lec !== 1'b0) begin
            errors++;
            $display("FAIL reset_wide: got q=%h tc=%b load_err=%b, want 0000 0 0", qc, tcc, lec);
         end
      end
      load = 1'b0; en = 1'b0; c_load = 1'b0; c_en = 1'b0;
      rstn = 1'b1;
   endtask

   task automatic test_count_up();
      limit = 8'h59; up = 1'b1; en = 1'b1;
      for (int i = 1; i <= 60; i++) begin
         step();
         chk_a($sformatf("up_%0d", i), (i < 60) ? bcd2(i) : 8'h00, (i == 60), 1'b0);
         chk_b($sformatf("up_%0d", i), (i < 60) ? bcd2(i) : 8'h59, (i == 60), 1'b0);
      end
      en = 1'b0;
      step();
      chk_a("up_hold", 8'h00, 1'b0, 1'b0);
      chk_b("up_hold", 8'h59, 1'b0, 1'b0);
   endtask

   task automatic test_count_down();
      limit = 8'h23;
      load_ab(8'h00);
      chk_a("dn_load", 8'h00, 1'b0, 1'b0);
      up = 1'b0; en = 1'b1;
      step();
      chk_a("dn_wrap", 8'h23, 1'b1, 1'b0);
      chk_b("dn_floor", 8'h00, 1'b1, 1'b0);
      for (int k = 1; k <= 23; k++) begin
         step();
         chk_a($sformatf("dn_%0d", k), bcd2(23 - k), 1'b0, 1'b0);
      end
      en = 1'b0;
   endtask

   task automatic test_saturate();
      limit = 8'h99;
      load_ab(8'h98);
      up = 1'b1; en = 1'b1;
      step();
      chk_a("sat_1", 8'h99, 1'b0, 1'b0);
      chk_b("sat_1", 8'h99, 1'b0, 1'b0);
      step();
      chk_a("sat_2", 8'h00, 1'b1, 1'b0);
      chk_b("sat_2", 8'h99, 1'b1, 1'b0);
      step();
      chk_a("sat_3", 8'h01, 1'b0, 1'b0);
      chk_b("sat_3", 8'h99, 1'b1, 1'b0);
      en = 1'b0;
   endtask

   task automatic test_load_err();
      load = 1'b1; en = 1'b1; up = 1'b1; load_val = 8'h3A;
      step();
      chk_a("ld_bad", 8'h01, 1'b0, 1'b1);
      chk_b("ld_bad", 8'h99, 1'b0, 1'b1);
      en = 1'b0; load_val = 8'h42;
      step();
      chk_a("ld_good", 8'h42, 1'b0, 1'b0);
      chk_b("ld_good", 8'h42, 1'b0, 1'b0);
      load = 1'b0;
      step();
      chk_a("ld_idle", 8'h42, 1'b0, 1'b0);
   endtask

   task automatic test_clr_priority();
      load_ab(8'h37);
      chk_a("clr_pre", 8'h37, 1'b0, 1'b0);
      clr = 1'b1; load = 1'b1; load_val = 8'h3A; en = 1'b1; up = 1'b1;
      step();
      chk_a("clr_prio", 8'h00, 1'b0, 1'b0);
      chk_b("clr_prio", 8'h00, 1'b0, 1'b0);
      clr = 1'b0; load = 1'b0; en = 1'b0;
   endtask

   task automatic test_limit_zero();
      limit = 8'h00; up = 1'b1; en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         chk_a("lim0", 8'h00, 1'b1, 1'b0);
      end
      en = 1'b0;
      limit = 8'h5B;
      #1;
      checks++;
      if (lima !== 1'b1) begin
         errors++;
         $display("FAIL lim_err_bad: got %b, want 1", lima);
      end
      limit = 8'h59;
      #1;
      checks++;
      if (lima !== 1'b0) begin
         errors++;
         $display("FAIL lim_err_ok: got %b, want 0", lima);
      end
   endtask

   task automatic test_wide();
      c_load = 1'b1; c_load_val = 16'h0999; c_en = 1'b0;
      step();
      c_load = 1'b0; c_en = 1'b1; c_up = 1'b1;
      step();
      checks++;
      if (qc !== 16'h1000 || tcc !== 1'b0) begin
         errors++;
         $display("FAIL wide_ripple_up: got q=%h tc=%b, want 1000 0", qc, tcc);
      end
      c_up = 1'b0;
      step();
      checks++;
      if (qc !== 16'h0999 || tcc !== 1'b0) begin
         errors++;
         $display("FAIL wide_ripple_dn: got q=%h tc=%b, want 0999 0", qc, tcc);
      end
      c_load = 1'b1; c_load_val = 16'h9999; c_en = 1'b0;
      step();
      c_load = 1'b0; c_en = 1'b1; c_up = 1'b1;
      step();
      checks++;
      if (qc !== 16'h0000 || tcc !== 1'b1) begin
         errors++;
         $display("FAIL wide_wrap: got q=%h tc=%b, want 0000 1", qc, tcc);
      end
      c_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_count_down();
      test_saturate();
      test_load_err();
      test_clr_priority();
      test_limit_zero();
      test_wide();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
